branch_resolve_unit: RTL

//  Parametrised EX-stage branch/jump resolver with a direction predictor. Selects forwarded operands,

---
 rtl/branch_resolve_unit_pkg.sv | 42 ++++
 rtl/branch_resolve_unit_if.sv | 51 +++++
 rtl/branch_resolve_unit_bht.sv | 37 +++
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and helpers for the EX-stage branch resolver.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: RV32I control-flow opcodes, B-type func3 codes, 2-bit counter
// encodings, the forwarding-select width helper, and the counter update rule.
package bru_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating direction counter; MSB is the prediction.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Select 0 is the register file, 1..num_fwd the forwarding sources.
    function automatic int sel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of the EX-stage request, fetch predictor lookup and resolver results.
// Latency: n/a (wires only).
// Backpressure: none; stall/flush_in are carried here and honoured by the resolver.
//
// master: the pipeline side (drives EX instruction, operands, fetch_pc).
// slave : the resolver (drives fetch_pred and the registered result pulses).
interface branch_resolve_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 4
);
    localparam int SELW = bru_pkg::sel_w(NUM_FWD);

    logic                    in_valid;
    logic                    stall;
    logic                    flush_in;
    logic [XLEN-1:0]         pc;
    logic [6:0]              opcode;
    logic [2:0]              func3;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [SELW-1:0]         fwd_sel1;
    logic [SELW-1:0]         fwd_sel2;
    logic                    pred_taken;
    logic [XLEN-1:0]         fetch_pc;
    logic                    fetch_pred;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic [XLEN-1:0]         link_data;
    logic                    b_en;
    logic                    jal_en;
    logic                    jalr_en;
    logic                    br_en;
    logic                    misalign_exc;

    modport master (
        output in_valid, stall, flush_in, pc, opcode, func3, imm, rs1_data, rs2_data,
               fwd_data, fwd_sel1, fwd_sel2, pred_taken, fetch_pc,
        input  fetch_pred, redirect_valid, redirect_pc, link_data, b_en, jal_en, jalr_en,
               br_en, misalign_exc
    );

    modport slave (
        input  in_valid, stall, flush_in, pc, opcode, func3, imm, rs1_data, rs2_data,
               fwd_data, fwd_sel1, fwd_sel2, pred_taken, fetch_pc,
        output fetch_pred, redirect_valid, redirect_pc, link_data, b_en, jal_en, jalr_en,
               br_en, misalign_exc
    );

endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: array of 2-bit saturating counters, reset to weakly not-taken.
// Latency: read is combinational; update lands on the next rising edge.
// Backpressure: none; caller gates upd_en_i.
//
// Ports: clk, rst (async, active-high), rd_idx_i -> rd_ctr_o (current value, so a
// same-cycle read of an index being updated returns the pre-update counter),
// upd_en_i / upd_idx_i / upd_taken_i train one entry per cycle.
module bru_bht
    import bru_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rd_idx_i,
    output logic [1:0]      rd_ctr_o,
    input  logic            upd_en_i,
    input  logic [IDXW-1:0] upd_idx_i,
    input  logic            upd_taken_i
);

    logic [1:0] ctr_q [DEPTH];

    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: operand forwarding, B-type compare, JAL/JALR targets, redirect.
// Latency: 1 cycle from capture to the registered result pulses; fetch_pred is combinational.
// Backpressure: stall or flush_in blocks capture and BHT training; outputs then pulse 0.
//
// Ports: clk, rst (async, active-high) and bus (branch_resolve_unit_if.slave).
// Build option BRU_PREDICTOR_EN: when defined, a BHT predicts fetch_pc and B-type
// redirects fire only on misprediction; when undefined, fetch predicts not-taken and
// every taken B-type redirects.
// redirect_pc carries the resolved next PC of any captured control-flow instruction,
// even when redirect_valid is low (e.g. misaligned target), so the faulting address is visible.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_FWD   = 4,
    parameter int BHT_DEPTH = 64
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave bus
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    logic            capture;
    logic            is_b;
    logic            is_jal;
    logic            is_jalr;
    logic            is_ctl;
    logic            br_taken;
    logic            mispredict;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] pc_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] next_pc;

    logic            redirect_valid_d, redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_d,    redirect_pc_q;
    logic [XLEN-1:0] link_data_d,      link_data_q;
    logic            b_en_d,           b_en_q;
    logic            jal_en_d,         jal_en_q;
    logic            jalr_en_d,        jalr_en_q;
    logic            br_en_d,          br_en_q;
    logic            misalign_d,       misalign_q;

    assign capture = bus.in_valid & ~bus.stall & ~bus.flush_in;
    assign is_b    = (bus.opcode == OP_BRANCH);
    assign is_jal  = (bus.opcode == OP_JAL);
    assign is_jalr = (bus.opcode == OP_JALR);
    assign is_ctl  = is_b | is_jal | is_jalr;

    // Selects beyond NUM_FWD match no source and fall back to the register file.
    always_comb begin
        op1 = bus.rs1_data;
        op2 = bus.rs2_data;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (int'(bus.fwd_sel1) == k + 1) begin
                op1 = bus.fwd_data[k*XLEN +: XLEN];
            end
            if (int'(bus.fwd_sel2) == k + 1) begin
                op2 = bus.fwd_data[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        case (bus.func3)
            F3_BEQ:  br_taken = (op1 == op2);
            F3_BNE:  br_taken = (op1 != op2);
            F3_BLT:  br_taken = ($signed(op1) <  $signed(op2));
            F3_BGE:  br_taken = ($signed(op1) >= $signed(op2));
            F3_BLTU: br_taken = (op1 <  op2);
            F3_BGEU: br_taken = (op1 >= op2);
            default: br_taken = 1'b0;
        endcase
    end

    // All target arithmetic wraps modulo 2^XLEN.
    assign seq_pc   = bus.pc + XLEN'(4);
    assign pc_tgt   = bus.pc + bus.imm;
    assign jalr_sum = op1 + bus.imm;

    always_comb begin
        if (is_jalr) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_b && !br_taken) begin
            next_pc = seq_pc;
        end else begin
            next_pc = pc_tgt;
        end
    end

`ifdef BRU_PREDICTOR_EN
    logic [1:0] fetch_ctr;
    logic       unused_bht;

    bru_bht #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (bus.fetch_pc[IDXW+1:2]),
        .rd_ctr_o    (fetch_ctr),
        .upd_en_i    (capture & is_b),
        .upd_idx_i   (bus.pc[IDXW+1:2]),
        .upd_taken_i (br_taken)
    );

    assign bus.fetch_pred = fetch_ctr[1];
    assign mispredict     = br_taken ^ bus.pred_taken;
    assign unused_bht     = ^{fetch_ctr[0], bus.fetch_pc[XLEN-1:IDXW+2], bus.fetch_pc[1:0]};
`else
    logic unused_pred;

    // Static not-taken: any taken branch is a misprediction.
    assign bus.fetch_pred = 1'b0;
    assign mispredict     = br_taken;
    assign unused_pred    = ^{bus.fetch_pc, bus.pred_taken, IDXW[0]};
`endif

    always_comb begin
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        link_data_d      = '0;
        b_en_d           = 1'b0;
        jal_en_d         = 1'b0;
        jalr_en_d        = 1'b0;
        br_en_d          = 1'b0;
        misalign_d       = 1'b0;
        if (capture && is_ctl) begin
            b_en_d        = is_b;
            jal_en_d      = is_jal;
            jalr_en_d     = is_jalr;
            br_en_d       = is_b & br_taken;
            link_data_d   = is_b ? '0 : seq_pc;
            redirect_pc_d = next_pc;
            // Only a taken path can fault; a not-taken branch falls through to pc+4.
            misalign_d    = (!is_b || br_taken) && next_pc[1];
            redirect_valid_d = !misalign_d && (is_b ? mispredict : 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            link_data_q      <= '0;
            b_en_q           <= 1'b0;
            jal_en_q         <= 1'b0;
            jalr_en_q        <= 1'b0;
            br_en_q          <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            link_data_q      <= link_data_d;
            b_en_q           <= b_en_d;
            jal_en_q         <= jal_en_d;
            jalr_en_q        <= jalr_en_d;
            br_en_q          <= br_en_d;
            misalign_q       <= misalign_d;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.link_data      = link_data_q;
    assign bus.b_en           = b_en_q;
    assign bus.jal_en         = jal_en_q;
    assign bus.jalr_en        = jalr_en_q;
    assign bus.br_en          = br_en_q;
    assign bus.misalign_exc   = misalign_q;

endmodule
